// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front end with FWFT byte FIFO.
//
// Deserialises 8N1 frames from the asynchronous rxd pin and pushes each good byte into a
// first-word-fall-through FIFO. The core pops one byte per rd_en strobe.
// With UART_RX_PARITY_EN defined, frames are 8E1 and a parity_err flag is added.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   rxd        raw serial line (idle high, asynchronous to clk)
//   rd_en      pop strobe, ignored while the FIFO is empty
//   rd_data    head-of-FIFO byte, valid while rd_valid=1
//   rd_valid   FIFO not empty
//   count      FIFO occupancy
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte completed while FIFO full and not being popped
//   parity_err sticky: parity mismatch (UART_RX_PARITY_EN only)
//   err_clr    synchronous clear of the sticky flags; a same-cycle set wins
module uart_rx_fifo #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rxd,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             frame_err,
    output logic             overrun,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             err_clr
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e state_q, state_d;
    logic          rx_meta_q, rx_s;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          brk_q, brk_d;      // stop bit was low; waiting for line to return high
    logic          stop_sample, push_req, frame_set;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d, parity_set, parity_err_q;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             full, pop, do_push, ovr_set, frame_err_q, overrun_q;

    // Two-flop synchroniser, idle high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s      <= rx_meta_q;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        brk_d   = brk_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                idx_d  = '0;
                brk_d  = 1'b0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // Mid-start-bit check rejects short glitches.
                if (tick_q == TICK_HALF) begin
                    tick_d  = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (tick_q == TICK_FULL) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = StParity;
`else
                    if (idx_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick_q == TICK_FULL) begin
                    tick_d  = '0;
                    par_d   = rx_s;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (brk_q) begin
                    tick_d = '0;
                    if (rx_s) state_d = StIdle;
                end else if (tick_q == TICK_FULL) begin
                    tick_d = '0;
                    if (rx_s) state_d = StIdle;
                    else      brk_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: events raised on the stop-sample cycle.
    always_comb begin
        stop_sample = (state_q == StStop) && !brk_q && (tick_q == TICK_FULL);
        frame_set   = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
        parity_set  = stop_sample && rx_s && ((^shift_q) ^ par_q);
        push_req    = stop_sample && rx_s && !parity_set;
`else
        push_req    = stop_sample && rx_s;
`endif
    end

    // FIFO control. A pop in the same cycle frees the slot for a push into a full FIFO.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = rd_en && rd_valid;
    assign do_push  = push_req && (!full || pop);
    assign ovr_set  = push_req && full && !pop;
    // Forced to zero while empty so the output is defined out of reset.
    assign rd_data  = rd_valid ? mem[rd_ptr_q[PW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[PW-1:0]] <= shift_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (frame_set)    frame_err_q <= 1'b1;
            else if (err_clr) frame_err_q <= 1'b0;
            if (ovr_set)      overrun_q   <= 1'b1;
            else if (err_clr) overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (parity_set)   parity_err_q <= 1'b1;
            else if (err_clr) parity_err_q <= 1'b0;
`endif
        end
    end

    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with CLK_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rxd = 1'b1;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_fifo #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: byte queue plus sticky flags.
    logic [7:0] q[$];
    bit m_fe = 0;
    bit m_ov = 0;
    bit m_pe = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        if (q.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
`ifdef UART_RX_PARITY_EN
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
`endif
    endtask

    // Send one frame, starting at a negedge. pop_stop pulses rd_en in the stop-sample cycle.
    task automatic send(input logic [7:0] d, input bit stop_v, input bit pop_stop,
                        input bit par_flip);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rxd = stop_v;
        for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            rd_en = pop_stop && (j == 9);
        end
        rxd = 1'b1;
        if (pop_stop && q.size() != 0) void'(q.pop_front());
        if (!stop_v) m_fe = 1;
        else if (par_flip) m_pe = 1;
        else if (q.size() < DEPTH) q.push_back(d);
        else m_ov = 1;
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_fe = 0;
        m_ov = 0;
        m_pe = 0;
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.rd_data", 32'(rd_data), 32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte, then pop.
        send(8'hA5, 1, 0, 0);
        check_all("a5");
        pop1();
        check_all("a5_pop");

        // Back-to-back frames fill the FIFO exactly.
        send(8'h00, 1, 0, 0);
        send(8'hFF, 1, 0, 0);
        send(8'h3C, 1, 0, 0);
        send(8'h81, 1, 0, 0);
        check_all("b2b_full");
        for (int i = 0; i < 4; i++) begin
            pop1();
            check_all("b2b_pop");
        end

        // Overrun on a full FIFO.
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 0, 0);
        check_all("fill");
        send(8'h55, 1, 0, 0);
        check_all("overrun");
        clear_flags();
        check_all("ovr_clr");

        // Pop in the stop-sample cycle of a byte arriving at a full FIFO.
        send(8'h77, 1, 1, 0);
        check_all("full_pop_push");
        for (int i = 0; i < 4; i++) begin
            pop1();
            check_all("drain");
        end

        // Short glitch is ignored.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_all("glitch");

        // Framing error, then a good frame.
        send(8'h12, 0, 0, 0);
        repeat (8) @(negedge clk);
        check_all("frame_err");
        send(8'h6B, 1, 0, 0);
        check_all("after_ferr");
        clear_flags();
        check_all("ferr_clr");

`ifdef UART_RX_PARITY_EN
        send(8'h03, 1, 0, 0);
        check_all("par_ok");
        send(8'h03, 1, 0, 1);
        check_all("par_bad");
        clear_flags();
        check_all("par_clr");
`endif

        // Randomized frames and pops against the model.
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send(b, 1, bit'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) pop1();
            check_all("rand");
        end

        // Asynchronous reset in the middle of a frame.
        if (q.size() == 0) send(8'hC3, 1, 0, 0);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        q.delete();
        m_fe = 0;
        m_ov = 0;
        m_pe = 0;
        check_all("mid_reset");
        chk("mid_reset.rd_data", 32'(rd_data), 32'h0);
        rxd = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h5A, 1, 0, 0);
        check_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
